jpeg_quant_scheduler: RTL

//  Controller that shares one 8x8 quantizer datapath between the Y, Cb and Cr 8x8 DCT block sources.
//  Per cycle: weighted round-robin arbitration, issue of the winning block, luma/chroma table select.

---
 rtl/jpeg_qsched_pkg.sv | 24 ++
 rtl/qsched_tag_ring.sv | 61 ++++++
 rtl/jpeg_quant_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/jpeg_qsched_pkg.sv
// Shared types for the JPEG quantizer scheduler.
// Component codes, Q-table selects and round-robin successor.
package jpeg_qsched_pkg;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  localparam logic QTAB_LUMA   = 1'b0;
  localparam logic QTAB_CHROMA = 1'b1;

  function automatic comp_e next_comp(input comp_e c);
    comp_e n;
    unique case (c)
      COMP_Y:  n = COMP_CB;
      COMP_CB: n = COMP_CR;
      default: n = COMP_Y;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qsched_tag_ring.sv
// Issue-order tag ring: comp code per result slot, issue/done/read
// pointers (one extra wrap bit) and the free-slot credit counter.
module qsched_tag_ring
  import jpeg_qsched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_issue,
  input  comp_e                    i_comp,
  input  logic                     i_done,
  input  logic                     i_out_ready,
  output logic                     o_credit_ok,
  output logic                     o_inflight,
  output logic [$clog2(DEPTH)-1:0] o_cap_idx,
  output logic                     o_out_valid,
  output comp_e                    o_out_comp,
  output logic [$clog2(DEPTH)-1:0] o_out_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW:0] PONE = 1;
  localparam logic [CW-1:0] CONE = 1;

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_dptr;
  logic [AW:0]   r_rptr;
  logic [CW-1:0] r_credits;
  comp_e         r_tag [DEPTH];
  logic          w_consume;

  assign o_credit_ok = (r_credits != '0);
  assign o_inflight  = (r_dptr != r_wptr);
  assign o_out_valid = (r_rptr != r_dptr);
  assign w_consume   = o_out_valid & i_out_ready;
  assign o_cap_idx   = r_dptr[AW-1:0];
  assign o_out_idx   = r_rptr[AW-1:0];
  assign o_out_comp  = r_tag[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_dptr    <= '0;
      r_rptr    <= '0;
      r_credits <= CW'(DEPTH);
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= COMP_Y;
    end else begin
      if (i_issue) begin
        r_tag[r_wptr[AW-1:0]] <= i_comp;
        r_wptr <= r_wptr + PONE;
      end
      if (i_done) r_dptr <= r_dptr + PONE;
      if (w_consume) r_rptr <= r_rptr + PONE;
      if (i_issue && !w_consume) r_credits <= r_credits - CONE;
      else if (!i_issue && w_consume) r_credits <= r_credits + CONE;
    end
  end

endmodule

// File: rtl/jpeg_quant_scheduler.sv
// Weighted round-robin scheduler sharing one quantizer among Y/Cb/Cr.
// Optional: JPEG_QSCHED_ERR_CHECK_EN flags stray quantizer result strobes.
module jpeg_quant_scheduler
  import jpeg_qsched_pkg::*;
#(
  parameter int RESULT_DEPTH = 4,
  parameter int Y_WEIGHT     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2:0]                      req_valid,
  output logic [2:0]                      req_ready,
  output logic                            q_enable,
  output logic [1:0]                      q_src_sel,
  output logic                            q_table_sel,
  input  logic                            q_out_enable,
  output logic [$clog2(RESULT_DEPTH)-1:0] cap_idx,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [1:0]                      out_comp,
  output logic [$clog2(RESULT_DEPTH)-1:0] out_idx,
  output logic                            err_unexpected
);

  localparam int WW = $clog2(Y_WEIGHT + 1);
  localparam logic [WW-1:0] WONE = 1;

  comp_e         r_prio;
  comp_e         w_prio_nxt;
  logic [WW-1:0] r_wcnt;
  logic [WW-1:0] w_wcnt_nxt;
  comp_e         w_sel;
  comp_e         w_out_comp;
  logic          w_credit_ok;
  logic          w_inflight;
  logic          w_issue;
  logic          w_done;

  // Grants are held off while rst is high so outputs read idle.
  assign w_issue = (|req_valid) & w_credit_ok & ~rst;
  assign w_done  = q_out_enable & w_inflight;

  always_comb begin
    w_sel = COMP_Y;
    unique case (r_prio)
      COMP_CB: begin
        if (req_valid[1])      w_sel = COMP_CB;
        else if (req_valid[2]) w_sel = COMP_CR;
        else                   w_sel = COMP_Y;
      end
      COMP_CR: begin
        if (req_valid[2])      w_sel = COMP_CR;
        else if (req_valid[0]) w_sel = COMP_Y;
        else                   w_sel = COMP_CB;
      end
      default: begin
        if (req_valid[0])      w_sel = COMP_Y;
        else if (req_valid[1]) w_sel = COMP_CB;
        else                   w_sel = COMP_CR;
      end
    endcase
  end

  assign req_ready   = w_issue ? (3'b001 << w_sel) : 3'b000;
  assign q_enable    = w_issue;
  assign q_src_sel   = w_issue ? w_sel : COMP_Y;
  assign q_table_sel = (w_issue && w_sel != COMP_Y) ? QTAB_CHROMA
                                                    : QTAB_LUMA;

  always_comb begin
    w_prio_nxt = r_prio;
    w_wcnt_nxt = r_wcnt;
    if (w_issue) begin
      if (w_sel != COMP_Y) begin
        w_prio_nxt = next_comp(w_sel);
        w_wcnt_nxt = '0;
      end else if (r_wcnt >= WW'(Y_WEIGHT - 1)
                   && (req_valid[1] || req_valid[2])) begin
        w_prio_nxt = COMP_CB;
        w_wcnt_nxt = '0;
      end else begin
        w_prio_nxt = COMP_Y;
        if (r_wcnt < WW'(Y_WEIGHT)) w_wcnt_nxt = r_wcnt + WONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= COMP_Y;
      r_wcnt <= '0;
    end else begin
      r_prio <= w_prio_nxt;
      r_wcnt <= w_wcnt_nxt;
    end
  end

  qsched_tag_ring #(
    .DEPTH(RESULT_DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .i_issue     (w_issue),
    .i_comp      (w_sel),
    .i_done      (w_done),
    .i_out_ready (out_ready),
    .o_credit_ok (w_credit_ok),
    .o_inflight  (w_inflight),
    .o_cap_idx   (cap_idx),
    .o_out_valid (out_valid),
    .o_out_comp  (w_out_comp),
    .o_out_idx   (out_idx)
  );

  assign out_comp = w_out_comp;

`ifdef JPEG_QSCHED_ERR_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_err <= 1'b0;
    else if (q_out_enable && !w_inflight) r_err <= 1'b1;
  end

  assign err_unexpected = r_err;
`else
  assign err_unexpected = 1'b0;
`endif

endmodule
